prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning idle cycles after the last byte that end a load.
REQ-002 SHALL have parameter MAX_WORDS, default 16384, meaning the ROM depth in 32-bit words.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port list (name, direction, width, meaning):
 - clk  in  1  system clock.
 - rst  in  1  async active-low reset.
 - load_req  in  1  synchronous pulse that starts a program download.
 - rx_valid  in  1  one-cycle strobe; rx_byte is valid.
 - rx_byte  in  8  received byte.
 - fetch_addr  in  14  CPU word fetch address (pc[15:2]).
 - rom_we  out  1  program ROM write enable.
 - rom_addr  out  14  program ROM address.
 - rom_wdata  out  32  program ROM write data.
 - cpu_rst_n  out  1  CPU reset, active low.
 - busy  out  1  load in progress.
 - load_done  out  1  sticky; set when a load completes.
 - err  out  1  sticky; partial last word or overflow.
 - word_count  out  14  words written by the last or current load.
 - chk_sum  out  32  running sum of written words.

Function
REQ-005 SHALL implement the states IDLE, WAIT_FIRST, LOAD, FLUSH and DONE.
REQ-006 load_req in IDLE or DONE SHALL enter WAIT_FIRST and clear word_count, byte index, chk_sum, load_done and err; load_req in any other state SHALL be ignored.
REQ-007 WAIT_FIRST SHALL wait indefinitely; the first rx_valid SHALL go to LOAD, and that byte counts as data.
REQ-008 Bytes SHALL pack little-endian: byte index 0 goes to [7:0] and index 3 goes to [31:24]; the index wraps 3->0.
REQ-009 On the cycle after the 4th byte is captured, rom_we=1, rom_addr=word_count and rom_wdata=the packed word, for exactly one cycle; word_count SHALL increment on that same edge.
REQ-010 In LOAD, a timeout counter SHALL reset on every rx_valid and increment otherwise; reaching TIMEOUT_CYCLES-1 SHALL exit LOAD.
REQ-011 On timeout with byte index 0, the block SHALL go to DONE.
REQ-012 On timeout with byte index nonzero, the block SHALL go to FLUSH, write the partial word zero-padded in one cycle, set err, then go to DONE.
REQ-013 When word_count reaches MAX_WORDS, further bytes SHALL be dropped, err SHALL be set, and the block SHALL go to DONE immediately.
REQ-014 An rx_valid that coincides with a rom_we cycle SHALL be captured without loss.
REQ-015 DONE SHALL set load_done; busy=1 only in WAIT_FIRST, LOAD and FLUSH.
REQ-016 In IDLE and DONE, rom_addr SHALL equal fetch_addr combinationally and rom_we=0.
REQ-017 cpu_rst_n SHALL be registered: 0 while busy, 1 otherwise.
REQ-018 cpu_rst_n SHALL rise on the clock edge entering DONE, so the CPU restarts at pc 0.

Reset
REQ-019 rst low SHALL asynchronously force state IDLE and drive rom_we=0, cpu_rst_n=0, busy=0, load_done=0, err=0, word_count=0, chk_sum=0, byte index=0 and timeout counter=0.
REQ-020 cpu_rst_n SHALL rise on the first clk edge after rst deasserts.
REQ-021 Reset during a load SHALL abandon the load; words already written remain in ROM.

Configuration
REQ-022 With LOAD_CHECKSUM_EN defined, chk_sum SHALL accumulate the 32-bit sum of every word written, modulo 2^32, including a flushed partial word.
REQ-023 Without LOAD_CHECKSUM_EN, chk_sum SHALL be constant 0 and the adder SHALL not be synthesised.

Structure
REQ-024 A shared package SHALL hold the state encoding, ROM_AW=14 and WORD_W=32.
REQ-025 One sub-module, byte_packer, SHALL perform byte-to-word assembly and emit a word_valid pulse.
REQ-026 The FSM, timeout logic and ROM port mux SHALL reside in prog_load_ctrl.

Verification
REQ-027 Reset then idle: fetch_addr=0x0005 -> rom_addr=0x0005, rom_we=0, cpu_rst_n=1 after the first edge.
REQ-028 load_req, then bytes 0x13,0x00,0x00,0x00,0xB7,0x12,0x00,0x00, then timeout -> writes 0x00000013@0 and 0x000012B7@1; word_count=2; load_done=1; err=0; chk_sum=0x000012CA with the macro, 0 without.
REQ-029 Load of 5 bytes (4 bytes then 0xAA) with timeout -> 0x000000AA written @1 via FLUSH; err=1; word_count=2.
REQ-030 rx_valid in the cycle of rom_we -> no byte lost; the next word is correct.
REQ-031 rst low mid-LOAD after 6 bytes -> state IDLE and cpu_rst_n=0 immediately; after release, busy=0 and load_done=0.
REQ-032 MAX_WORDS=2 with 12 bytes sent -> exactly 2 writes; err=1; DONE entered on the 2nd write.

Source files
------------

// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and widths for the program loader.
// State encoding plus ROM address and data widths.
package prog_load_ctrl_pkg;
    localparam int ROM_AW = 14;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_e;
endpackage

// File: rtl/prog_load_ctrl_byte_packer.sv
// Little-endian byte-to-word assembler for the program loader.
// Emits a registered one-cycle word_valid pulse after the 4th byte.
module byte_packer
    import prog_load_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o,
    output logic [WORD_W-1:0] part_o,
    output logic [1:0]        idx_o
);
    logic [1:0]        idx_q;
    logic [WORD_W-1:0] buf_q;
    logic [WORD_W-1:0] word_q;
    logic              wv_q;
    logic [WORD_W-1:0] merged;

    always_comb begin
        merged = buf_q;
        merged[{idx_q, 3'b000} +: 8] = byte_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            buf_q  <= '0;
            word_q <= '0;
            wv_q   <= 1'b0;
        end else begin
            wv_q <= 1'b0;
            if (clr_i) begin
                idx_q <= '0;
                buf_q <= '0;
            end else if (byte_valid_i) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // buffer restarts empty so a later flush is zero-padded
                    word_q <= merged;
                    wv_q   <= 1'b1;
                    buf_q  <= '0;
                end else begin
                    buf_q <= merged;
                end
            end
        end
    end

    assign word_valid_o = wv_q;
    assign word_o       = word_q;
    assign part_o       = buf_q;
    assign idx_o        = idx_q;
endmodule

// File: rtl/prog_load_ctrl.sv
// Serial program loader: packs rx bytes into ROM words, holds the CPU in reset.
// Optional LOAD_CHECKSUM_EN enables the running chk_sum adder.
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_WORDS      = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [ROM_AW-1:0] fetch_addr,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              load_done,
    output logic              err,
    output logic [ROM_AW-1:0] word_count,
    output logic [WORD_W-1:0] chk_sum
);
    localparam logic [31:0]     TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [ROM_AW:0] LAST_WORD = (ROM_AW + 1)'(MAX_WORDS - 1);

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] wc_q, wc_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              crst_q;
    logic              start;
    logic              we;
    logic              pk_clr;
    logic              pk_valid;
    logic              pk_wv;
    logic [WORD_W-1:0] pk_word;
    logic [WORD_W-1:0] pk_part;
    logic [1:0]        pk_idx;
    logic              at_last;
    logic              rom_own;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst),
        .clr_i        (pk_clr),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_byte),
        .word_valid_o (pk_wv),
        .word_o       (pk_word),
        .part_o       (pk_part),
        .idx_o        (pk_idx)
    );

    assign rom_own = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start   = load_req && rom_own;
    assign at_last = ({1'b0, wc_q} == LAST_WORD);

    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        tmo_d    = tmo_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clr   = 1'b0;
        pk_valid = 1'b0;
        we       = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT_FIRST;
                    wc_d    = '0;
                    tmo_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    pk_clr  = 1'b1;
                end
            end
            ST_WAIT_FIRST: begin
                if (rx_valid) begin
                    pk_valid = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pk_valid = rx_valid && !(pk_wv && at_last);
                tmo_d    = rx_valid ? '0 : tmo_q + 32'd1;
                if (pk_wv) begin
                    we   = 1'b1;
                    wc_d = wc_q + 1'b1;
                end
                if (pk_wv && at_last) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (!rx_valid && tmo_q == TMO_LAST) begin
                    state_d = (pk_idx == 2'd0) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                we      = 1'b1;
                wc_d    = wc_q + 1'b1;
                err_d   = 1'b1;
                pk_clr  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wc_q    <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            crst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            // tracks next state so the CPU leaves reset on the DONE edge
            crst_q  <= !((state_d == ST_WAIT_FIRST) ||
                         (state_d == ST_LOAD) ||
                         (state_d == ST_FLUSH));
        end
    end

    assign rom_we     = we;
    assign rom_addr   = rom_own ? fetch_addr : wc_q;
    assign rom_wdata  = (state_q == ST_FLUSH) ? pk_part : pk_word;
    assign busy       = !rom_own;
    assign cpu_rst_n  = crst_q;
    assign load_done  = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

`ifdef LOAD_CHECKSUM_EN
    logic [WORD_W-1:0] chk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= '0;
        end else if (start) begin
            chk_q <= '0;
        end else if (we) begin
            chk_q <= chk_q + rom_wdata;
        end
    end

    assign chk_sum = chk_q;
`else
    assign chk_sum = '0;
`endif
endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized bench for prog_load_ctrl against a byte-list reference model.
// A second instance with MAX_WORDS=2 covers the overflow path.
module tb_prog_load_ctrl;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        sel = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic [13:0] fetch = '0;

    logic        a_we, a_crst, a_busy, a_done, a_err;
    logic [13:0] a_addr, a_wc;
    logic [31:0] a_wdata, a_chk;
    logic        b_we, b_crst, b_busy, b_done, b_err;
    logic [13:0] b_addr, b_wc;
    logic [31:0] b_wdata, b_chk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_load_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_WORDS(16384)) u_a (
        .clk(clk), .rst(rst_n), .load_req(load && !sel),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .fetch_addr(fetch),
        .rom_we(a_we), .rom_addr(a_addr), .rom_wdata(a_wdata),
        .cpu_rst_n(a_crst), .busy(a_busy), .load_done(a_done),
        .err(a_err), .word_count(a_wc), .chk_sum(a_chk)
    );

    prog_load_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_WORDS(2)) u_b (
        .clk(clk), .rst(rst_n), .load_req(load && sel),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .fetch_addr(fetch),
        .rom_we(b_we), .rom_addr(b_addr), .rom_wdata(b_wdata),
        .cpu_rst_n(b_crst), .busy(b_busy), .load_done(b_done),
        .err(b_err), .word_count(b_wc), .chk_sum(b_chk)
    );

    wire        s_we   = sel ? b_we   : a_we;
    wire        s_busy = sel ? b_busy : a_busy;
    wire        s_crst = sel ? b_crst : a_crst;
    wire        s_done = sel ? b_done : a_done;
    wire        s_err  = sel ? b_err  : a_err;
    wire [13:0] s_addr = sel ? b_addr : a_addr;
    wire [13:0] s_wc   = sel ? b_wc   : a_wc;
    wire [31:0] s_wd   = sel ? b_wdata : a_wdata;
    wire [31:0] s_chk  = sel ? b_chk  : a_chk;

    logic [45:0] wr_q[$];
    logic [7:0]  bytes_q[$];
    logic [31:0] exp_w[$];
    logic        exp_err;
    logic [31:0] exp_chk;
    logic        pend2 = 1'b0;
    logic        busy_after2 = 1'b1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pend2) begin
            busy_after2 = b_busy;
            pend2 = 1'b0;
        end
        if (s_we) begin
            wr_q.push_back({s_addr, s_wd});
            if (sel && wr_q.size() == 2) pend2 = 1'b1;
        end
    end

    task automatic build_exp(input int maxw);
        int n, total, nw;
        logic [31:0] w;
        n = bytes_q.size();
        total = (n + 3) / 4;
        nw = (total > maxw) ? maxw : total;
        exp_w.delete();
        exp_chk = '0;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++)
                if (4 * i + k < n) w = w | (32'(bytes_q[4 * i + k]) << (8 * k));
            exp_w.push_back(w);
            exp_chk = exp_chk + w;
        end
`ifndef LOAD_CHECKSUM_EN
        exp_chk = '0;
`endif
        exp_err = (n % 4 != 0) || (total >= maxw);
    endtask

    task automatic send_bytes(input int gmax);
        int g;
        foreach (bytes_q[i]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = bytes_q[i];
            g = (gmax == 0) ? 0 : $urandom_range(gmax, 0);
            repeat (g) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input int gmax, input int maxw);
        int cyc, n;
        wr_q.delete();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check({tag, ".busy"}, 64'(s_busy), 64'd1);
        check({tag, ".crst_lo"}, 64'(s_crst), 64'd0);
        send_bytes(gmax);
        cyc = 0;
        while (s_busy && cyc < 20 * TMO + 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".finish"}, 64'(s_busy), 64'd0);
        build_exp(maxw);
        check({tag, ".nwr"}, 64'(wr_q.size()), 64'(exp_w.size()));
        n = (wr_q.size() < exp_w.size()) ? wr_q.size() : exp_w.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.wr%0d", tag, i), 64'(wr_q[i]),
                  64'({14'(i), exp_w[i]}));
        check({tag, ".wc"}, 64'(s_wc), 64'(exp_w.size()));
        check({tag, ".done"}, 64'(s_done), 64'd1);
        check({tag, ".err"}, 64'(s_err), 64'(exp_err));
        check({tag, ".chk"}, 64'(s_chk), 64'(exp_chk));
        check({tag, ".crst_hi"}, 64'(s_crst), 64'd1);
        fetch = 14'($urandom);
        #1;
        check({tag, ".fetch"}, 64'(s_addr), 64'(fetch));
        check({tag, ".we_idle"}, 64'(s_we), 64'd0);
    endtask

    initial begin
        int len;
        fetch = 14'h0005;
        repeat (2) @(negedge clk);
        check("rst.we", 64'(a_we), 64'd0);
        check("rst.crst", 64'(a_crst), 64'd0);
        check("rst.busy", 64'(a_busy), 64'd0);
        check("rst.done", 64'(a_done), 64'd0);
        check("rst.err", 64'(a_err), 64'd0);
        check("rst.wc", 64'(a_wc), 64'd0);
        check("rst.chk", 64'(a_chk), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.crst", 64'(a_crst), 64'd1);
        check("idle.addr", 64'(a_addr), 64'h5);
        check("idle.we", 64'(a_we), 64'd0);

        bytes_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h00, 8'h00};
        run_load("two_words", 2, 16384);
`ifdef LOAD_CHECKSUM_EN
        check("two_words.chk_const", 64'(a_chk), 64'h12CA);
`else
        check("two_words.chk_const", 64'(a_chk), 64'h0);
`endif

        bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        run_load("flush", 1, 16384);

        bytes_q.delete();
        for (int i = 0; i < 12; i++) bytes_q.push_back(8'($urandom));
        run_load("b2b", 0, 16384);

        for (int t = 0; t < 8; t++) begin
            bytes_q.delete();
            len = $urandom_range(23, 1);
            for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", t), 3, 16384);
        end

        wr_q.delete();
        bytes_q.delete();
        for (int i = 0; i < 6; i++) bytes_q.push_back(8'($urandom));
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        send_bytes(0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(a_busy), 64'd0);
        check("midrst.crst", 64'(a_crst), 64'd0);
        check("midrst.wc", 64'(a_wc), 64'd0);
        build_exp(16384);
        check("midrst.nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() >= 1)
            check("midrst.wr0", 64'(wr_q[0]), 64'({14'd0, exp_w[0]}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.busy_after", 64'(a_busy), 64'd0);
        check("midrst.done_after", 64'(a_done), 64'd0);
        check("midrst.crst_after", 64'(a_crst), 64'd1);

        sel = 1'b1;
        bytes_q.delete();
        for (int i = 0; i < 12; i++) bytes_q.push_back(8'($urandom));
        run_load("max", 0, 2);
        check("max.done_on_2nd", 64'(busy_after2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
